// File: rtl/spec_carry_checker.sv
// rtl/spec_carry_checker.sv - segmented carry-speculation adder with mispredict check and one-cycle correction (optional SPEC_ERR_CNT_EN error counter)
module spec_carry_checker #(
    parameter int WIDTH = 16,
    localparam int NSEG = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             spec_err
`ifdef SPEC_ERR_CNT_EN
    ,
    output logic [15:0]      err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        CORRECT = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             cin_r;

    logic [WIDTH:0]   exact;
    logic [WIDTH-1:0] spec_sum;
    logic [NSEG-1:1]  c_true;
    logic [NSEG-1:1]  c_pred;
    logic             err;

    assign in_ready = (state == IDLE);

    // Exact sum of the registered operands; its top bit is the true carry out.
    assign exact = {1'b0, a_r} + {1'b0, b_r} + {{WIDTH{1'b0}}, cin_r};

    // Per-segment true carry (recovered from the exact sum) versus predicted carry,
    // plus the speculative sum built from 4-bit segments fed by the predictions.
    always_comb begin
        c_true   = '0;
        c_pred   = '0;
        spec_sum = '0;
        spec_sum[3:0] = a_r[3:0] + b_r[3:0] + {3'b000, cin_r};
        for (int i = 1; i < NSEG; i++) begin
            c_true[i] = exact[4*i] ^ a_r[4*i] ^ b_r[4*i];
            c_pred[i] = a_r[4*i-1] & b_r[4*i-1];
            spec_sum[4*i +: 4] = a_r[4*i +: 4] + b_r[4*i +: 4] + {3'b000, c_pred[i]};
        end
        err = |(c_pred ^ c_true);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a mispredicted add detours through CORRECT.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = CHECK;
            CHECK:   state_next = err ? CORRECT : HOLD;
            CORRECT: state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture on the accepting edge only; ignored in every other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            cin_r <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_r   <= a;
            b_r   <= b;
            cin_r <= cin;
        end
    end

    // Result registers: the speculative sum is only loaded when it is already exact,
    // otherwise CORRECT loads the exact sum; results persist after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            cout      <= 1'b0;
            spec_err  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                CHECK: begin
                    if (!err) begin
                        sum       <= spec_sum;
                        cout      <= exact[WIDTH];
                        spec_err  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                CORRECT: begin
                    sum       <= exact[WIDTH-1:0];
                    cout      <= exact[WIDTH];
                    spec_err  <= 1'b1;
                    out_valid <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef SPEC_ERR_CNT_EN
    // Saturating count of corrected results; every CORRECT cycle moves to HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (state == CORRECT && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spec_carry_checker.sv
// tb/tb_spec_carry_checker.sv - self-checking bench for spec_carry_checker
module tb_spec_carry_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        spec_err;
`ifdef SPEC_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int tests = 0;
    int fails = 0;

    spec_carry_checker #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .spec_err  (spec_err)
`ifdef SPEC_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: transaction-level view of what must be visible each cycle.
    int m_busy, m_valid, m_lat, m_cout, m_err, m_errs;
    int m_sum;
    int p_sum, p_cout, p_err;

    function automatic void predict(input int av, input int bv, input int cv,
                                    output int s, output int co, output int e);
        int total, lo, mask, tru, prd;
        total = av + bv + cv;
        s  = total % 65536;
        co = (total >= 65536) ? 1 : 0;
        e  = 0;
        for (int k = 1; k < 4; k++) begin
            lo   = 4 * k;
            mask = (1 << lo) - 1;
            tru  = (((av & mask) + (bv & mask) + cv) >= (1 << lo)) ? 1 : 0;
            prd  = ((av >> (lo - 1)) & (bv >> (lo - 1))) & 1;
            if (tru != prd) e = 1;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_valid = 0; m_lat = 0;
            m_sum = 0; m_cout = 0; m_err = 0; m_errs = 0;
        end else if (m_valid != 0) begin
            if (out_ready) begin
                m_valid = 0;
                m_busy  = 0;
            end
        end else if (m_busy != 0) begin
            m_lat--;
            if (m_lat == 0) begin
                m_valid = 1;
                m_sum   = p_sum;
                m_cout  = p_cout;
                m_err   = p_err;
                if (p_err != 0 && m_errs < 65535) m_errs++;
            end
        end else if (in_valid) begin
            predict(int'(a), int'(b), int'(cin), p_sum, p_cout, p_err);
            m_busy = 1;
            m_lat  = (p_err != 0) ? 2 : 1;
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        chk("cyc_in_ready",  32'(in_ready),  32'(m_busy == 0));
        chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
        chk("cyc_sum",       32'(sum),       32'(m_sum));
        chk("cyc_cout",      32'(cout),      32'(m_cout));
        chk("cyc_spec_err",  32'(spec_err),  32'(m_err));
`ifdef SPEC_ERR_CNT_EN
        chk("cyc_err_cnt",   32'(err_cnt),   32'(m_errs));
`endif
    end

    // Present one transaction, wait for the result, check literal expectations; leave it in HOLD.
    task automatic run_txn(input string name, input logic [15:0] av, input logic [15:0] bv,
                           input logic cv, input logic [15:0] es, input logic ec,
                           input logic ee);
        int lat;
        @(negedge clk);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), ee ? 32'd2 : 32'd1);
        chk({name, "_sum"}, 32'(sum), 32'(es));
        chk({name, "_cout"}, 32'(cout), 32'(ec));
        chk({name, "_spec_err"}, 32'(spec_err), 32'(ee));
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'h0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_spec_err", 32'(spec_err), 32'd0);
        #2 rst_n = 1'b1;

        run_txn("add_1_2",   16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0); release_result();
        run_txn("add_f_1",   16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b1);
`ifdef SPEC_ERR_CNT_EN
        chk("err_cnt_one", 32'(err_cnt), 32'd1);
`endif
        release_result();
        run_txn("add_0808",  16'h0808, 16'h0808, 1'b0, 16'h1010, 1'b0, 1'b0); release_result();
        run_txn("add_nocar", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0); release_result();
        run_txn("add_msb",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0); release_result();
        run_txn("add_allf",  16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0); release_result();

        // Wrap-around with a long HOLD and an ignored request during it.
        run_txn("wrap", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2); a = 16'h1111; b = 16'h2222; cin = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_sum", 32'(sum), 32'h0000);
            chk("hold_cout", 32'(cout), 32'd1);
        end
        in_valid = 1'b0;
        release_result();
        chk("after_hold_sum_kept", 32'(sum), 32'h0000);

        // Reset asserted during the CORRECT cycle discards the transaction.
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_sum", 32'(sum), 32'h0);
`ifdef SPEC_ERR_CNT_EN
        chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_result", 32'(out_valid), 32'd0);
        end

        run_txn("post_rst_add", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b1); release_result();

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
